// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes (RISC-V
// funct3 encoding), FSM state type and a helper that folds the eight size
// codes into byte / half / word access classes.
package lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {IDLE, WAIT} lsu_state_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_class_t;

    // Codes 3, 6 and 7 have no defined meaning and are handled as words.
    function automatic size_class_t size_class(input logic [2:0] size);
        size_class_t cls;
        case (size)
            LDST_B, LDST_BU: cls = SZ_BYTE;
            LDST_H, LDST_HU: cls = SZ_HALF;
            default:         cls = SZ_WORD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the memory word
// and sign- or zero-extends it. Bit 2 of the size code selects unsigned.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rd,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] rd_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension; words pass straight through.
    always_comb begin
        byte_sel = mem_rd[7:0];
        case (offset)
            2'd0:    byte_sel = mem_rd[7:0];
            2'd1:    byte_sel = mem_rd[15:8];
            2'd2:    byte_sel = mem_rd[23:16];
            default: byte_sel = mem_rd[31:24];
        endcase
        half_sel = offset[1] ? mem_rd[31:16] : mem_rd[15:0];
        rd_data  = mem_rd;
        case (size_class(size))
            SZ_BYTE: rd_data = {{24{byte_sel[7] & ~size[2]}}, byte_sel};
            SZ_HALF: rd_data = {{16{half_sel[15] & ~size[2]}}, half_sel};
            default: rd_data = mem_rd;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit between the core data port and data memory.
// Handshake: the core raises core_req_i and holds its inputs while
// core_stall_o is high; the unit issues a one-cycle mem_req_o, then waits in
// WAIT until memory answers with mem_ready_i, on which edge both the unit
// and the core advance. Load data is valid on core_rd_o in that ready cycle.
// Optional build macro: LSU_MISALIGN_CHECK_EN adds misaligned_o and rejects
// misaligned half/word accesses instead of silently ignoring low bits.
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i,
    input  logic              mem_ready_i
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    output logic              misaligned_o
`endif
);

    lsu_state_t  state_q, state_d;
    logic [1:0]  off_q;
    logic [2:0]  size_q;
    logic        we_q;
    logic        misaligned;
    logic        req_fire;
    logic [31:0] load_data;
    size_class_t req_class;

    assign req_class = size_class(core_size_i);

`ifdef LSU_MISALIGN_CHECK_EN
    // Misaligned half/word requests are rejected in IDLE for one cycle.
    always_comb begin
        misaligned = (state_q == IDLE) && core_req_i &&
                     (((req_class == SZ_HALF) && core_addr_i[0]) ||
                      ((req_class == SZ_WORD) && (core_addr_i[1:0] != 2'b00)));
    end
    assign misaligned_o = misaligned;
`else
    assign misaligned = 1'b0;
`endif

    assign req_fire   = (state_q == IDLE) && core_req_i && !misaligned;
    assign mem_addr_o = {core_addr_i[ADDR_W-1:2], 2'b00};

    // State register and capture of the access attributes used by the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            off_q   <= 2'b00;
            size_q  <= 3'b000;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                off_q  <= core_addr_i[1:0];
                size_q <= core_size_i;
                we_q   <= core_we_i;
            end
        end
    end

    // Next state, request pulse and stall.
    always_comb begin
        state_d      = state_q;
        mem_req_o    = 1'b0;
        core_stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                mem_req_o    = req_fire;
                core_stall_o = req_fire;
                if (req_fire) state_d = WAIT;
            end
            WAIT: begin
                core_stall_o = !mem_ready_i;
                if (mem_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte enables and lane-replicated store data, driven only with the request.
    always_comb begin
        mem_we_o = 1'b0;
        mem_be_o = 4'b0000;
        mem_wd_o = 32'h0;
        if (req_fire) begin
            mem_we_o = core_we_i;
            mem_be_o = 4'b1111;
            if (core_we_i) begin
                case (req_class)
                    SZ_BYTE: begin
                        mem_be_o = 4'b0001 << core_addr_i[1:0];
                        mem_wd_o = {4{core_wd_i[7:0]}};
                    end
                    SZ_HALF: begin
                        mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
                        mem_wd_o = {2{core_wd_i[15:0]}};
                    end
                    default: mem_wd_o = core_wd_i;
                endcase
            end
        end
    end

    lsu_load_align u_load_align (
        .mem_rd  (mem_rd_i),
        .offset  (off_q),
        .size    (size_q),
        .rd_data (load_data)
    );

    // Load data is only presented while a load response is outstanding.
    always_comb begin
        core_rd_o = 32'h0;
        if ((state_q == WAIT) && !we_q) core_rd_o = load_data;
    end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
Load/store unit between processor_core's data-memory port and data_mem. It replaces the system-level stall toggle with a proper request/ready handshake. It generates byte enables and replicated store data from mem_size, and holds the core stalled until memory signals ready. It also aligns and sign/zero-extends load data.

Parameters:
ADDR_W, 32, width of core and memory address buses.

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-high reset
core_req_i  input  1  core requests a memory access this cycle
core_we_i  input  1  1 = store, 0 = load
core_size_i  input  3  access size, RISC-V funct3 encoding
core_addr_i  input  ADDR_W  byte address
core_wd_i  input  32  store data, right-justified
core_rd_o  output  32  aligned and extended load data
core_stall_o  output  1  core must hold its PC and inputs
mem_req_o  output  1  memory request pulse
mem_we_o  output  1  memory write enable
mem_be_o  output  4  byte enables
mem_addr_o  output  ADDR_W  word-aligned address, {core_addr_i[ADDR_W-1:2],2'b00}
mem_wd_o  output  32  lane-replicated store data
mem_rd_i  input  32  memory read word
mem_ready_i  input  1  memory has completed the request; read data valid

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is asynchronous and active-high.
- Reset state:
  - FSM = IDLE; captured offset, size and we registers = 0.
  - Outputs are combinational from the inputs and state per the rules below.
  - The core is held in reset simultaneously, so core_req_i = 0 and thus mem_req_o = 0, core_stall_o = 0, core_rd_o = 0.
- FSM states: IDLE, WAIT.
- IDLE:
  - mem_req_o = core_req_i.
  - core_stall_o = core_req_i.
  - On core_req_i: capture core_addr_i[1:0], core_size_i and core_we_i; go to WAIT.
- WAIT:
  - mem_req_o = 0; mem_we_o, mem_be_o and mem_wd_o = 0.
  - core_stall_o = !mem_ready_i.
  - On mem_ready_i: go to IDLE. The core advances on this same edge.
- Latency: minimum 2 cycles per access (request cycle, then ready cycle). Each extra cycle with ready low adds 1 stall cycle.
- mem_ready_i asserted while in IDLE is ignored.
- Back-to-back accesses: after the ready cycle, the FSM is in IDLE. A new core_req_i is then issued immediately, with no bubble beyond the mandatory request cycle.
- Store byte enables and data, valid in the IDLE request cycle only (off = core_addr_i[1:0]):
  - SB (0): mem_be_o = 4'b0001 << off; mem_wd_o = {4{wd[7:0]}}.
  - SH (1): mem_be_o = 4'b0011 << {off[1],1'b0}; mem_wd_o = {2{wd[15:0]}}.
  - SW (2): mem_be_o = 4'b1111; mem_wd_o = wd.
  - Loads: mem_be_o = 4'b1111; mem_wd_o = 0.
- Load extraction, using the captured offset and size; core_rd_o is combinational from mem_rd_i:
  - LB (0): sign-extend byte at lane off.
  - LBU (4): zero-extend byte at lane off.
  - LH (1): sign-extend half at lane off[1].
  - LHU (5): zero-extend half at lane off[1].
  - LW (2): full word.
- core_rd_o = 0 when the FSM is not in WAIT or the captured access is a store.
- Unsupported size codes 3, 6, 7 are treated as word (W) for both loads and stores.
- Misalignment (without the optional feature): off[0] is ignored for halfwords; off[1:0] is ignored for words.
- Reset mid-operation: the FSM returns to IDLE and the pending response is dropped. A late mem_ready_i is then ignored.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined:
  - Adds output port misaligned_o (1 bit).
  - Misaligned access in IDLE: half with off[0] = 1, or word with off != 0.
  - On a misaligned access: mem_req_o = 0, misaligned_o = 1 for that single cycle, core_stall_o = 0, FSM stays in IDLE.
  - core_rd_o = 0 for that cycle.
- Undefined: no misaligned_o port; low address bits are ignored as in Behaviour.

Decomposition:
- lsu_pkg:
  - Size localparams LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5.
  - typedef enum logic {IDLE, WAIT} lsu_state_t.
- Sub-module lsu_load_align: combinational; inputs mem_rd, offset and size; output extended data. Instantiated once.

Test Plan:
- SW addr 0x104, wd 0xDEADBEEF:
  - Request cycle: mem_req_o=1, mem_be_o=1111, mem_addr_o=0x104, mem_wd_o=0xDEADBEEF.
  - Ready next cycle: stall high for exactly 1 cycle.
- SB addr 0x203, wd 0x000000A5: mem_be_o=1000, mem_wd_o=0xA5A5A5A5, mem_addr_o=0x200.
- LB addr 0x2, mem_rd_i 0x00800000: core_rd_o=0xFFFFFF80. Same access as LBU: core_rd_o=0x00000080.
- LH addr 0x6, mem_rd_i 0x8001FFFF: core_rd_o=0xFFFF8001. Same access as LHU: core_rd_o=0x00008001.
- LW with ready held low 3 cycles after the request: core_stall_o high for 4 cycles; mem_req_o high only in the first cycle.
- Assert rst_i while in WAIT, then pulse mem_ready_i: FSM in IDLE, no stall, core_rd_o=0.
  - With LSU_MISALIGN_CHECK_EN defined, LW at 0x101: misaligned_o=1, mem_req_o=0.
